// File: rtl/control_word_sequencer_pkg.sv
// Shared types and bit positions for the ICW/OCW control word sequencer.
// The flag vector packs the five write requests so one edge detector serves all of them.
package control_word_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_UNINIT,
      ST_WAIT_ICW2,
      ST_WAIT_ICW3,
      ST_WAIT_ICW4,
      ST_READY
   } cws_state_e;

   localparam int NUM_FLAGS    = 5;
   localparam int FLAG_ICW1    = 0;
   localparam int FLAG_ICW2_4  = 1;
   localparam int FLAG_OCW1    = 2;
   localparam int FLAG_OCW2    = 3;
   localparam int FLAG_OCW3    = 4;

   localparam int ICW1_IC4     = 0;
   localparam int ICW1_SNGL    = 1;
   localparam int ICW1_LTIM    = 3;
   localparam int OCW3_ESMM    = 6;
   localparam int OCW3_SMM     = 5;
   localparam int OCW3_P       = 2;
   localparam int OCW3_RR      = 1;
   localparam int OCW3_RIS     = 0;

   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
   localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
   localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
   localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;
   localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;

   // Every programmed control bit plus the three command pulses, held as one record.
   typedef struct packed {
      logic       ltim;
      logic       single_mode;
      logic       ic4;
      logic [4:0] vector_base;
      logic [7:0] cascade_config;
      logic       upm;
      logic       aeoi;
      logic [1:0] buffered_mode;
      logic       sfnm;
      logic [7:0] imr;
      logic       ocw2_valid;
      logic [2:0] ocw2_cmd;
      logic [2:0] ocw2_level;
      logic       rotate_on_aeoi;
      logic       special_mask_mode;
      logic       read_isr;
      logic       poll_pulse;
      logic       init_pulse;
   } cws_regs_t;

endpackage

// File: rtl/control_word_sequencer_strobe_edge_detect.sv
// Turns level write-request flags into single-cycle fire strobes.
// History clears on reset so a flag already high at release fires once.
module strobe_edge_detect #(
   parameter int WIDTH       = 5,
   parameter bit EDGE_DETECT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] flags_i,
   output logic [WIDTH-1:0] fire_o
);

   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
      end else begin
         prev_q <= flags_i;
      end
   end

   generate
      if (EDGE_DETECT) begin : g_edge
         assign fire_o = flags_i & ~prev_q;
      end else begin : g_level
         assign fire_o = flags_i;
      end
   endgenerate

endmodule

// File: rtl/control_word_sequencer.sv
// Sequences ICW1..ICW4 initialization and decodes OCW1..OCW3 writes,
// holding every programmed control register for the interrupt controller core.
module control_word_sequencer
   import control_word_sequencer_pkg::*;
#(
   parameter bit EDGE_DETECT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] internal_data_bus,
   input  logic       ICW1,
   input  logic       ICW2_4,
   input  logic       OCW1,
   input  logic       OCW2,
   input  logic       OCW3,
   output logic       init_done,
   output logic       init_pulse,
   output logic       ltim,
   output logic       single_mode,
   output logic [4:0] vector_base,
   output logic [7:0] cascade_config,
   output logic       upm,
   output logic       aeoi,
   output logic [1:0] buffered_mode,
   output logic       sfnm,
   output logic [7:0] imr,
   output logic       ocw2_valid,
   output logic [2:0] ocw2_cmd,
   output logic [2:0] ocw2_level,
   output logic       rotate_on_aeoi,
   output logic       special_mask_mode,
   output logic       read_isr,
   output logic       poll_pulse
);

   logic [NUM_FLAGS-1:0] flags;
   logic [NUM_FLAGS-1:0] fire;
   cws_state_e           state_q, state_d;
   cws_regs_t            regs_q, regs_d;
   logic [7:0]           d;

   assign d = internal_data_bus;

   always_comb begin
      flags              = '0;
      flags[FLAG_ICW1]   = ICW1;
      flags[FLAG_ICW2_4] = ICW2_4;
      flags[FLAG_OCW1]   = OCW1;
      flags[FLAG_OCW2]   = OCW2;
      flags[FLAG_OCW3]   = OCW3;
   end

   strobe_edge_detect #(
      .WIDTH       (NUM_FLAGS),
      .EDGE_DETECT (EDGE_DETECT)
   ) u_edge (
      .clk     (clk),
      .reset   (reset),
      .flags_i (flags),
      .fire_o  (fire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_UNINIT;
         regs_q  <= '0;
      end else begin
         state_q <= state_d;
         regs_q  <= regs_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      regs_d            = regs_q;
      regs_d.init_pulse = 1'b0;
      regs_d.ocw2_valid = 1'b0;
      regs_d.poll_pulse = 1'b0;

      // ICW1 restarts initialization from any state and swallows every other flag.
      if (fire[FLAG_ICW1]) begin
         state_d                  = ST_WAIT_ICW2;
         regs_d.init_pulse        = 1'b1;
         regs_d.ltim              = d[ICW1_LTIM];
         regs_d.single_mode       = d[ICW1_SNGL];
         regs_d.ic4               = d[ICW1_IC4];
         regs_d.imr               = '0;
         regs_d.special_mask_mode = 1'b0;
         regs_d.read_isr          = 1'b0;
         regs_d.rotate_on_aeoi    = 1'b0;
         regs_d.ocw2_cmd          = '0;
         regs_d.ocw2_level        = '0;
         regs_d.cascade_config    = '0;
         regs_d.upm               = 1'b0;
         regs_d.aeoi              = 1'b0;
         regs_d.buffered_mode     = '0;
         regs_d.sfnm              = 1'b0;
      end else begin
         unique case (state_q)
            ST_WAIT_ICW2: begin
               if (fire[FLAG_ICW2_4]) begin
                  regs_d.vector_base = d[7:3];
                  if (!regs_q.single_mode) begin
                     state_d = ST_WAIT_ICW3;
                  end else if (regs_q.ic4) begin
                     state_d = ST_WAIT_ICW4;
                  end else begin
                     state_d = ST_READY;
                  end
               end
            end
            ST_WAIT_ICW3: begin
               if (fire[FLAG_ICW2_4]) begin
                  regs_d.cascade_config = d;
                  state_d = regs_q.ic4 ? ST_WAIT_ICW4 : ST_READY;
               end
            end
            ST_WAIT_ICW4: begin
               if (fire[FLAG_ICW2_4]) begin
                  regs_d.sfnm          = d[4];
                  regs_d.buffered_mode = d[3:2];
                  regs_d.aeoi          = d[1];
                  regs_d.upm           = d[0];
                  state_d              = ST_READY;
               end
            end
            ST_READY: begin
               // A0=1 writes mean IMR once operational; ICW2_4 is dropped here.
               if (fire[FLAG_OCW1]) begin
                  regs_d.imr = d;
               end
               if (fire[FLAG_OCW2]) begin
                  regs_d.ocw2_valid = 1'b1;
                  regs_d.ocw2_cmd   = d[7:5];
                  regs_d.ocw2_level = d[2:0];
                  if (d[7:5] == OCW2_SET_ROT_AEOI) begin
                     regs_d.rotate_on_aeoi = 1'b1;
                  end else if (d[7:5] == OCW2_CLR_ROT_AEOI) begin
                     regs_d.rotate_on_aeoi = 1'b0;
                  end
               end
               if (fire[FLAG_OCW3]) begin
                  if (d[OCW3_ESMM]) begin
                     regs_d.special_mask_mode = d[OCW3_SMM];
                  end
                  if (d[OCW3_RR]) begin
                     regs_d.read_isr = d[OCW3_RIS];
                  end
                  regs_d.poll_pulse = d[OCW3_P];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign init_done         = (state_q == ST_READY);
   assign init_pulse        = regs_q.init_pulse;
   assign ltim              = regs_q.ltim;
   assign single_mode       = regs_q.single_mode;
   assign vector_base       = regs_q.vector_base;
   assign cascade_config    = regs_q.cascade_config;
   assign upm               = regs_q.upm;
   assign aeoi              = regs_q.aeoi;
   assign buffered_mode     = regs_q.buffered_mode;
   assign sfnm              = regs_q.sfnm;
   assign imr               = regs_q.imr;
   assign ocw2_valid        = regs_q.ocw2_valid;
   assign ocw2_cmd          = regs_q.ocw2_cmd;
   assign ocw2_level        = regs_q.ocw2_level;
   assign rotate_on_aeoi    = regs_q.rotate_on_aeoi;
   assign special_mask_mode = regs_q.special_mask_mode;
   assign read_isr          = regs_q.read_isr;
   assign poll_pulse        = regs_q.poll_pulse;

endmodule
